// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, FIFO instruction buffer, redirect flush.
// Buffer depth is 1 by default, 2 when FETCH_PREFETCH_EN is defined.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

`ifdef FETCH_PREFETCH_EN
   localparam logic [1:0] DEPTH = 2'd2;
`else
   localparam logic [1:0] DEPTH = 2'd1;
`endif

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        run_q;

   logic [31:0] buf_inst_q [2];
   logic [31:0] buf_pc_q   [2];
   logic        rd_ptr_q, wr_ptr_q;
   logic [1:0]  cnt_q;

   logic        pop, do_pop, push, buf_free, req_fire;
   logic        unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign pop      = inst_valid & inst_ready;
   assign do_pop   = pop & ~redirect_valid;
   assign buf_free = (cnt_q < DEPTH) | pop;
   assign req_fire = imem_req_valid & imem_req_ready;
   // A request only issues with space reserved, so a kept response always fits.
   assign push     = (state_q == WAIT) & imem_rsp_valid & ~redirect_valid;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         req_pc_q <= 32'h0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         run_q    <= 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      case (state_q)
         IDLE: begin
            if (req_fire) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A response coinciding with a redirect retires the request and is dropped.
            if (imem_rsp_valid) begin
               state_d = IDLE;
            end else if (redirect_valid) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (imem_rsp_valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (redirect_valid) begin
         pc_d = {redirect_pc[31:2], 2'b00};
      end else if (req_fire) begin
         pc_d     = pc_q + 32'd4;
         req_pc_d = pc_q;
      end
   end

   // Output logic
   always_comb begin
      imem_req_valid = run_q & (state_q == IDLE) & buf_free & ~redirect_valid;
      imem_req_addr  = pc_q;
      inst_valid     = (cnt_q != 2'd0);
      inst           = buf_inst_q[rd_ptr_q];
      inst_pc        = buf_pc_q[rd_ptr_q];
   end

   // Instruction buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            buf_inst_q[i] <= 32'h0;
            buf_pc_q[i]   <= 32'h0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else if (redirect_valid) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            buf_inst_q[wr_ptr_q] <= imem_rsp_data;
            buf_pc_q[wr_ptr_q]   <= req_pc_q;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, do_pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a simple latency-programmable imem model.
module tb_fetch_stage;

`ifdef FETCH_PREFETCH_EN
   localparam int EXP_ENT = 2;
`else
   localparam int EXP_ENT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   int          n_chk = 0;
   int          n_bad = 0;
   logic [31:0] issued[$];
   logic [31:0] delivered[$];
   int          lat;
   logic        mem_pend;
   int          mem_cnt;
   logic [31:0] mem_addr;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'h5A3C_0F96;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock edge: sample handshakes before it, update the memory model after it.
   task automatic step();
      logic        acc;
      logic [31:0] acc_addr;
      logic        rsp_done;
      @(negedge clk);
      acc      = imem_req_valid & imem_req_ready & rst_n;
      acc_addr = imem_req_addr;
      rsp_done = imem_rsp_valid;
      if (acc) issued.push_back(acc_addr);
      if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
         delivered.push_back(inst_pc);
         chk("inst_word", inst, word_of(inst_pc));
      end
      @(posedge clk);
      #1;
      if (rsp_done) begin
         imem_rsp_valid = 1'b0;
         mem_pend       = 1'b0;
      end
      if (acc) begin
         mem_pend = 1'b1;
         mem_cnt  = lat;
         mem_addr = acc_addr;
      end
      if (mem_pend && !imem_rsp_valid) begin
         if (mem_cnt <= 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mem_addr);
         end else begin
            mem_cnt--;
         end
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      inst_ready     = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      mem_pend       = 1'b0;
      mem_cnt        = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      issued.delete();
      delivered.delete();
   endtask

   initial begin
      rst_n          = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      inst_ready     = 1'b0;
      lat            = 1;
      mem_pend       = 1'b0;
      mem_cnt        = 0;
      mem_addr       = 32'h0;

      // Reset state
      @(posedge clk);
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);

      // Streaming, 1-cycle latency
      do_reset();
      lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
      steps(10);
      chk("seq_addr0", issued[0], 32'h0);
      chk("seq_addr1", issued[1], 32'h4);
      chk("seq_addr2", issued[2], 32'h8);
      chk("seq_pc0", delivered[0], 32'h0);
      chk("seq_pc1", delivered[1], 32'h4);
      chk("seq_pc2", delivered[2], 32'h8);

      // Decode stall
      do_reset();
      lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
      steps(8);
      chk("stall_reqs", 32'(issued.size()), 32'(EXP_ENT));
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_head_pc", inst_pc, 32'h0);
      inst_ready = 1'b1;
      steps(2);
      chk("stall_burst", 32'(delivered.size()), 32'(EXP_ENT));
      steps(10);
      chk("stall_pc0", delivered[0], 32'h0);
      chk("stall_pc1", delivered[1], 32'h4);
      chk("stall_pc2", delivered[2], 32'h8);
      chk("stall_pc3", delivered[3], 32'hC);

      // Redirect while a request is outstanding
      do_reset();
      lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
      steps(2);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
      step();
      redirect_valid = 1'b0;
      chk("drain_req_valid", 32'(imem_req_valid), 32'd0);
      chk("drain_addr", imem_req_addr, 32'h0000_0100);
      steps(10);
      chk("redir_req", issued[1], 32'h0000_0100);
      chk("redir_pc0", delivered[0], 32'h0000_0100);

      // PC wrap
      do_reset();
      lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      steps(7);
      chk("wrap_req0", issued[0], 32'hFFFF_FFFC);
      chk("wrap_req1", issued[1], 32'h0);
      chk("wrap_pc0", delivered[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", delivered[1], 32'h0);

      // Redirect, pop and response together
      do_reset();
      lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
      steps(4);
      inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      step();
      redirect_valid = 1'b0;
      chk("flush_empty", 32'(inst_valid), 32'd0);
      chk("flush_delivered", 32'(delivered.size()), 32'd0);
      steps(8);
      chk("flush_pc0", delivered[0], 32'h0000_0200);

      // Reset during an outstanding request
      do_reset();
      lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
      steps(3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      mem_pend = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rsp_in_rst_valid", 32'(inst_valid), 32'd0);
      chk("rsp_in_rst_inst", inst, 32'h0);
      chk("rsp_in_rst_pc", inst_pc, 32'h0);
      chk("rsp_in_rst_req", 32'(imem_req_valid), 32'd0);
      imem_rsp_valid = 1'b0;
      rst_n = 1'b1;
      issued.delete();
      delivered.delete();
      chk("post_rst_no_req", 32'(imem_req_valid), 32'd0);
      steps(8);
      chk("post_rst_req0", issued[0], 32'h0);
      chk("post_rst_pc0", delivered[0], 32'h0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
